// File: rtl/matmul_feeder_if.sv
// rtl/matmul_feeder_if.sv - host request/response and systolic-array lane signals of the feeder
interface matmul_feeder_if;
    logic         start;
    logic [511:0] matA_flat;
    logic [511:0] matB_flat;
    logic         busy;
    logic         done;
    logic         timeout;
    logic [127:0] result_flat;
    logic         mm_input_start;
    logic [127:0] mm_inA_flat;
    logic [127:0] mm_inB_flat;
    logic [3:0]   mm_counter;
    logic [127:0] mm_outD_flat;
    logic         mm_output_rdy;

    modport master (
        output start, matA_flat, matB_flat, mm_outD_flat, mm_output_rdy,
        input  busy, done, timeout, result_flat,
        input  mm_input_start, mm_inA_flat, mm_inB_flat, mm_counter
    );

    modport slave (
        input  start, matA_flat, matB_flat, mm_outD_flat, mm_output_rdy,
        output busy, done, timeout, result_flat,
        output mm_input_start, mm_inA_flat, mm_inB_flat, mm_counter
    );
endinterface

// File: rtl/matmul_feeder.sv
// rtl/matmul_feeder.sv - skews latched 4x4 operands into a systolic array and captures its result
module matmul_feeder #(
    parameter int CAPTURE_CNT = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    matmul_feeder_if.slave        bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t       state_q, state_d;
    logic [511:0] a_q, a_d;
    logic [511:0] b_q, b_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] lane_a_q, lane_a_d;
    logic [127:0] lane_b_q, lane_b_d;
    logic         init_q, init_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         timeout_q, timeout_d;
    logic [127:0] result_q, result_d;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        timeout_d = timeout_q;
        result_d  = result_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d       = bus.matA_flat;
                    b_d       = bus.matB_flat;
                    timeout_d = 1'b0;
                    state_d   = CLEAR;
                end
            end
            CLEAR: state_d = FEED;
            FEED: begin
                if (cnt_q == 4'd6) state_d = DRAIN;
            end
            DRAIN: begin
                if (bus.mm_output_rdy && int'(cnt_q) >= CAPTURE_CNT) begin
                    result_d = bus.mm_outD_flat;
                    state_d  = DONE;
                end else if (cnt_q == 4'd15) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next state so every output leaves a flop.
    always_comb begin
        cnt_d    = 4'd0;
        init_d   = (state_d == CLEAR);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        lane_a_d = '0;
        lane_b_d = '0;
        if (state_d == FEED) begin
            cnt_d = (state_q == CLEAR) ? 4'd0 : cnt_q + 4'd1;
        end else if (state_d == DRAIN) begin
            if (state_q == FEED)        cnt_d = 4'd7;
            else if (cnt_q == 4'd15)    cnt_d = 4'd15;
            else                        cnt_d = cnt_q + 4'd1;
        end
        for (int k = 0; k < 4; k++) begin
            if (state_d == FEED && int'(cnt_d) >= k && int'(cnt_d) - k <= 3) begin
                lane_a_d[127-32*k -: 32] = a_q[511-32*(4*k + int'(cnt_d) - k) -: 32];
                lane_b_d[127-32*k -: 32] = b_q[511-32*(4*(int'(cnt_d) - k) + k) -: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            lane_a_q  <= '0;
            lane_b_q  <= '0;
            init_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            lane_a_q  <= lane_a_d;
            lane_b_q  <= lane_b_d;
            init_q    <= init_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            result_q  <= result_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.timeout        = timeout_q;
    assign bus.result_flat    = result_q;
    assign bus.mm_input_start = init_q;
    assign bus.mm_inA_flat    = lane_a_q;
    assign bus.mm_inB_flat    = lane_b_q;
    assign bus.mm_counter     = cnt_q;
endmodule

// File: tb/tb_matmul_feeder.sv
// tb/tb_matmul_feeder.sv - randomized scoreboard bench for matmul_feeder
module tb_matmul_feeder;
    localparam int CAP = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    matmul_feeder_if bus();
    matmul_feeder #(.CAPTURE_CNT(CAP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Array stand-in: result word tags the beat count it was offered at.
    logic [127:0] od_base;
    int           rdy_from;
    assign bus.mm_outD_flat  = {od_base[127:8], 4'h0, bus.mm_counter};
    assign bus.mm_output_rdy = (int'(bus.mm_counter) >= rdy_from);

    typedef struct { logic [127:0] a; logic [127:0] b; } beat_t;
    typedef struct { logic [127:0] res; logic to; int cyc; } done_t;
    beat_t exp_beats[$];
    done_t exp_done[$];
    int           pending_clr = 0;
    logic [127:0] model_res = '0;
    logic [127:0] hold_res = '0;
    logic [31:0]  ma[4][4];
    logic [31:0]  mb[4][4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=no_event", name);
    endtask

    // Reference: beat t presents a[k][t-k] and b[t-k][k] on lane k; capture at max(rdy point, CAP).
    task automatic issue(input int r_from, input logic [127:0] base);
        beat_t bt;
        done_t dn;
        int    c;
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++) begin
                bus.matA_flat[511-32*(4*r+cc) -: 32] = ma[r][cc];
                bus.matB_flat[511-32*(4*r+cc) -: 32] = mb[r][cc];
            end
        for (int t = 0; t < 7; t++) begin
            bt.a = '0;
            bt.b = '0;
            for (int k = 0; k < 4; k++)
                if (t - k >= 0 && t - k <= 3) begin
                    bt.a[127-32*k -: 32] = ma[k][t-k];
                    bt.b[127-32*k -: 32] = mb[t-k][k];
                end
            exp_beats.push_back(bt);
        end
        c = (r_from > CAP) ? r_from : CAP;
        if (c > 15) begin
            dn.res = model_res;
            dn.to  = 1'b1;
            dn.cyc = cyc + 1 + 17;
        end else begin
            dn.res = {base[127:8], 4'h0, 4'(c)};
            dn.to  = 1'b0;
            dn.cyc = cyc + 1 + c + 2;
        end
        model_res = dn.res;
        exp_done.push_back(dn);
        pending_clr++;
        od_base   = base;
        rdy_from  = r_from;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.matA_flat = {16{$urandom}};
        bus.matB_flat = {16{$urandom}};
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) fail_now("done_wait_expired");
    endtask

    task automatic rand_ops();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = $urandom;
                mb[r][c] = $urandom;
            end
    endtask

    task automatic pulse_ignored_start();
        bus.matA_flat = {16{$urandom}};
        bus.matB_flat = {16{$urandom}};
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    int    feed_idx = -1;
    int    drain_exp = 7;
    beat_t mb_pop;
    done_t md_pop;

    always @(negedge clk) begin
        if (!rst_n) begin
            feed_idx = -1;
        end else begin
            if (bus.done !== 1'b1) check("result_hold", bus.result_flat, hold_res);
            if (bus.mm_input_start) begin
                if (pending_clr == 0) fail_now("unexpected_clear");
                else begin
                    pending_clr--;
                    checks++;
                end
                check("clear_counter", 128'(bus.mm_counter), 128'd0);
                check("clear_laneA", bus.mm_inA_flat, '0);
                check("clear_laneB", bus.mm_inB_flat, '0);
                check("clear_busy", 128'(bus.busy), 128'd1);
                feed_idx = 0;
            end else if (feed_idx >= 0 && feed_idx < 7) begin
                if (exp_beats.size() == 0) fail_now("unexpected_beat");
                else begin
                    mb_pop = exp_beats.pop_front();
                    check("beat_laneA", bus.mm_inA_flat, mb_pop.a);
                    check("beat_laneB", bus.mm_inB_flat, mb_pop.b);
                end
                check("beat_counter", 128'(bus.mm_counter), 128'(feed_idx));
                feed_idx++;
                if (feed_idx == 7) drain_exp = 7;
            end else if (bus.busy && !bus.done) begin
                check("drain_counter", 128'(bus.mm_counter), 128'(drain_exp));
                check("drain_lanes", bus.mm_inA_flat | bus.mm_inB_flat, '0);
                drain_exp = (drain_exp < 15) ? drain_exp + 1 : 15;
            end else begin
                check("idle_counter", 128'(bus.mm_counter), 128'd0);
                check("idle_lanes", bus.mm_inA_flat | bus.mm_inB_flat, '0);
                check("idle_busy", 128'(bus.busy), 128'(bus.done));
            end
            if (bus.done === 1'b1) begin
                if (exp_done.size() == 0) fail_now("unexpected_done");
                else begin
                    md_pop = exp_done.pop_front();
                    check("done_result", bus.result_flat, md_pop.res);
                    check("done_timeout", 128'(bus.timeout), 128'(md_pop.to));
                    check("done_cycle", 128'(cyc), 128'(md_pop.cyc));
                    hold_res = md_pop.res;
                end
                feed_idx = -1;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 128'(bus.busy), 128'd0);
        check({tag, "_done"}, 128'(bus.done), 128'd0);
        check({tag, "_timeout"}, 128'(bus.timeout), 128'd0);
        check({tag, "_result"}, bus.result_flat, '0);
        check({tag, "_init"}, 128'(bus.mm_input_start), 128'd0);
        check({tag, "_lanes"}, bus.mm_inA_flat | bus.mm_inB_flat, '0);
        check({tag, "_counter"}, 128'(bus.mm_counter), 128'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_time_limit actual=running required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.matA_flat = '0;
        bus.matB_flat = '0;
        od_base       = '0;
        rdy_from      = 16;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        #1 rst_n = 1'b1;
        @(negedge clk);

        // identity times 1..16, capture exactly at CAP
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = (r == c) ? 32'd1 : 32'd0;
                mb[r][c] = 32'(4*r + c + 1);
            end
        issue(CAP, {$urandom, $urandom, $urandom, $urandom});
        wait_done();

        // A = 1..16 exercises every skew position, random rdy point
        @(negedge clk);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = 32'(4*r + c + 1);
                mb[r][c] = $urandom;
            end
        issue($urandom_range(0, 15), {$urandom, $urandom, $urandom, $urandom});
        wait_done();

        // array never ready -> saturate and time out, result kept
        @(negedge clk);
        rand_ops();
        issue(16, {$urandom, $urandom, $urandom, $urandom});
        wait_done();

        // start during FEED and during DONE must be ignored
        @(negedge clk);
        rand_ops();
        issue(CAP + 1, {$urandom, $urandom, $urandom, $urandom});
        repeat (3) @(negedge clk);
        pulse_ignored_start();
        wait_done();
        pulse_ignored_start();
        repeat (4) @(negedge clk);

        // reset during FEED beat 3
        rand_ops();
        issue(CAP, {$urandom, $urandom, $urandom, $urandom});
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midfeed_reset");
        exp_beats.delete();
        exp_done.delete();
        pending_clr = 0;
        model_res   = '0;
        hold_res    = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        rand_ops();
        issue(CAP, {$urandom, $urandom, $urandom, $urandom});
        wait_done();

        // back-to-back: start in the cycle after done, then a random run
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rand_ops();
            issue((i % 5 == 4) ? 16 : int'($urandom_range(0, 15)),
                  {$urandom, $urandom, $urandom, $urandom});
            wait_done();
            if (i % 3 == 2) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("queues_empty", 128'(exp_beats.size() + exp_done.size() + pending_clr), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
